// File: rtl/wb_classic_master.sv
// rtl/wb_classic_master.sv - Wishbone B4 classic single-transfer initiator with retry and timeout
module wb_classic_master #(
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic [3:0]  req_sel_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_RTY     = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_GAP,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            ready_en;
    logic            we_r;
    logic [31:0]     adr_r;
    logic [31:0]     dat_r;
    logic [3:0]      sel_r;
    logic [RW-1:0]   retry_cnt;
    logic [RW-1:0]   retry_nxt;
    logic [TW-1:0]   tmo_cnt;
    logic [TW-1:0]   tmo_nxt;
    logic [31:0]     rsp_dat_r;
    logic [1:0]      rsp_status_r;
    logic [1:0]      status_nxt;
    logic            accept;
    logic            capture;
    logic            bus_drive;

    always_comb begin
        state_nxt  = state;
        retry_nxt  = retry_cnt;
        tmo_nxt    = tmo_cnt;
        status_nxt = rsp_status_r;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid_i && ready_en) begin
                    accept     = 1'b1;
                    retry_nxt  = '0;
                    tmo_nxt    = '0;
                    status_nxt = ST_OK;
                    state_nxt  = S_BUS;
                end
            end
            S_BUS: begin
                if (err_i) begin
                    status_nxt = ST_ERR;
                    state_nxt  = S_RESP;
                end else if (ack_i) begin
                    status_nxt = ST_OK;
                    capture    = ~we_r;
                    state_nxt  = S_RESP;
                end else if (rty_i) begin
                    if (retry_cnt == RW'(MAX_RETRIES)) begin
                        status_nxt = ST_RTY;
                        state_nxt  = S_RESP;
                    end else begin
                        retry_nxt = retry_cnt + RW'(1);
                        tmo_nxt   = '0;
                        state_nxt = S_GAP;
                    end
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = S_RESP;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end
            S_GAP:   state_nxt = S_BUS;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            ready_en     <= 1'b0;
            we_r         <= 1'b0;
            adr_r        <= '0;
            dat_r        <= '0;
            sel_r        <= '0;
            retry_cnt    <= '0;
            tmo_cnt      <= '0;
            rsp_dat_r    <= '0;
            rsp_status_r <= '0;
        end else begin
            state        <= state_nxt;
            ready_en     <= 1'b1;
            retry_cnt    <= retry_nxt;
            tmo_cnt      <= tmo_nxt;
            rsp_status_r <= status_nxt;
            if (accept) begin
                we_r      <= req_we_i;
                adr_r     <= req_adr_i;
                dat_r     <= req_dat_i;
                sel_r     <= req_sel_i;
                rsp_dat_r <= '0;
            end else if (capture) begin
                rsp_dat_r <= dat_i;
            end
        end
    end

    // Outputs decode straight from state so an async reset clears the bus at once.
    assign bus_drive    = (state == S_BUS) || (state == S_GAP);
    assign cyc_o        = (state == S_BUS);
    assign stb_o        = (state == S_BUS);
    assign adr_o        = bus_drive ? adr_r : '0;
    assign dat_o        = bus_drive ? dat_r : '0;
    assign sel_o        = bus_drive ? sel_r : '0;
    assign we_o         = bus_drive & we_r;
    assign req_ready_o  = (state == S_IDLE) && ready_en;
    assign rsp_valid_o  = (state == S_RESP);
    assign rsp_dat_o    = rsp_valid_o ? rsp_dat_r : '0;
    assign rsp_status_o = rsp_valid_o ? rsp_status_r : '0;

endmodule

// File: tb/tb_wb_classic_master.sv
// tb/tb_wb_classic_master.sv - randomized self-checking bench for wb_classic_master
module tb_wb_classic_master;

    localparam int MAXR = 3;
    localparam int TMO  = 16;
    localparam int T_ACK  = 0;
    localparam int T_ERR  = 1;
    localparam int T_RTY  = 2;
    localparam int T_NONE = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_adr_i = '0;
    logic [31:0] req_dat_i = '0;
    logic [3:0]  req_sel_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    always #5 clk_i = ~clk_i;

    wb_classic_master #(.MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [1:0]  st;
        logic [31:0] rdat;
        int          bus;
        int          issues;
    } exp_t;

    exp_t        exp_q[$];
    int          plan_w[8];
    int          plan_t[8];
    int          plan_n = 1;
    int          slv_iss = -1;
    logic [31:0] slv_mem[16];
    logic [31:0] mdl_mem[16];
    bit          chk_en = 1'b0;
    int          rsp_in_reset = 0;
    int          n_rsp = 0;
    logic [31:0] last_dat;
    logic [1:0]  last_st;
    int          last_bus, last_iss;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: per-issue plan gives wait cycles then a termination kind.
    bit prev_cyc = 1'b0;
    int cyc_in = 0;
    always @(negedge clk_i) begin
        int idx;
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
        if (cyc_o && stb_o) begin
            if (!prev_cyc) begin
                slv_iss++;
                cyc_in = 0;
            end else begin
                cyc_in++;
            end
            idx = (slv_iss < plan_n) ? slv_iss : plan_n - 1;
            if (plan_t[idx] != T_NONE && cyc_in == plan_w[idx]) begin
                case (plan_t[idx])
                    T_ERR: begin err_i = 1'b1; ack_i = 1'b1; end
                    T_RTY: rty_i = 1'b1;
                    default: begin
                        ack_i = 1'b1;
                        if (we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (sel_o[b]) slv_mem[adr_o[5:2]][8*b +: 8] = dat_o[8*b +: 8];
                        end else begin
                            dat_i = slv_mem[adr_o[5:2]];
                        end
                    end
                endcase
            end
        end
        prev_cyc = cyc_o;
    end

    // Compare process.
    bit in_txn = 1'b0;
    bit pcyc = 1'b0;
    int elapsed = 0, cyc_cnt = 0, iss_cnt = 0;
    always @(negedge clk_i) begin
        exp_t e;
        if (!chk_en) begin
            in_txn = 1'b0;
            if (rsp_valid_o) rsp_in_reset++;
        end else begin
            check("stb_eq_cyc", {31'd0, stb_o}, {31'd0, cyc_o});
            if (in_txn) begin
                elapsed++;
                if (cyc_o) begin
                    cyc_cnt++;
                    if (!pcyc) iss_cnt++;
                end
            end
            if (cyc_o) begin
                check("bus_txn_open", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    check("bus_adr", adr_o, exp_q[0].adr);
                    check("bus_dat", dat_o, exp_q[0].dat);
                    check("bus_sel", {28'd0, sel_o}, {28'd0, exp_q[0].sel});
                    check("bus_we", {31'd0, we_o}, {31'd0, exp_q[0].we});
                end
            end
            if (rsp_valid_o) begin
                check("rsp_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_dat", rsp_dat_o, e.rdat);
                    check("rsp_status", {30'd0, rsp_status_o}, {30'd0, e.st});
                    check("bus_cycles", cyc_cnt, e.bus);
                    check("issues", iss_cnt, e.issues);
                    check("latency", elapsed, e.bus + e.issues);
                end
                check("resp_adr_zero", adr_o, 32'd0);
                check("resp_cyc_low", {31'd0, cyc_o}, 32'd0);
                last_dat = rsp_dat_o;
                last_st  = rsp_status_o;
                last_bus = cyc_cnt;
                last_iss = iss_cnt;
                in_txn   = 1'b0;
                n_rsp++;
            end else begin
                check("rsp_dat_idle", rsp_dat_o, 32'd0);
                check("rsp_status_idle", {30'd0, rsp_status_o}, 32'd0);
                if (req_ready_o) begin
                    check("idle_adr", adr_o, 32'd0);
                    check("idle_dat", dat_o, 32'd0);
                    check("idle_ctl", {27'd0, sel_o, we_o}, 32'd0);
                end else if (!cyc_o && in_txn && exp_q.size() > 0) begin
                    check("gap_adr_hold", adr_o, exp_q[0].adr);
                end
            end
            if (req_valid_i && req_ready_o) begin
                in_txn  = 1'b1;
                elapsed = 0;
                cyc_cnt = 0;
                iss_cnt = 0;
            end
        end
        pcyc = cyc_o;
    end

    task automatic set_plan1(input int t, input int w);
        plan_n = 1; plan_t[0] = t; plan_w[0] = w;
    endtask

    function automatic exp_t model(input logic we, input logic [31:0] adr,
                                   input logic [31:0] dat, input logic [3:0] sel);
        exp_t e;
        int   r = 0, i = 0, idx;
        bit   done = 1'b0;
        e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
        e.st = 2'd0; e.rdat = '0; e.bus = 0; e.issues = 0;
        while (!done) begin
            idx = (i < plan_n) ? i : plan_n - 1;
            e.issues++;
            if (plan_t[idx] == T_NONE || plan_w[idx] >= TMO) begin
                e.bus += TMO; e.st = 2'd3; done = 1'b1;
            end else begin
                e.bus += plan_w[idx] + 1;
                if (plan_t[idx] == T_ERR) begin
                    e.st = 2'd1; done = 1'b1;
                end else if (plan_t[idx] == T_ACK) begin
                    e.st = 2'd0; done = 1'b1;
                    if (we) begin
                        for (int b = 0; b < 4; b++)
                            if (sel[b]) mdl_mem[adr[5:2]][8*b +: 8] = dat[8*b +: 8];
                    end else begin
                        e.rdat = mdl_mem[adr[5:2]];
                    end
                end else if (r < MAXR) begin
                    r++; i++;
                end else begin
                    e.st = 2'd2; done = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic start_req(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        int k = 0;
        exp_q.push_back(model(we, adr, dat, sel));
        slv_iss = -1;
        @(posedge clk_i); #1;
        req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
        req_valid_i = 1'b1;
        do begin @(negedge clk_i); k++; end while (!req_ready_o && k < 20);
        check("accept", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_adr_i = $urandom; req_dat_i = $urandom; req_we_i = 1'($urandom); req_sel_i = 4'($urandom);
    endtask

    task automatic do_txn(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
        int got, k = 0;
        got = n_rsp;
        start_req(we, adr, dat, sel);
        while (n_rsp == got && k < 200) begin @(posedge clk_i); k++; end
        check("rsp_seen", (n_rsp == got) ? 32'd0 : 32'd1, 32'd1);
        #1;
        check("ready_after_rsp", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        int r;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 32'h1000_0000 + 32'(i);
            mdl_mem[i] = 32'h1000_0000 + 32'(i);
        end
        #1;
        check("rst_ready", {31'd0, req_ready_o}, 32'd0);
        check("rst_cyc", {30'd0, cyc_o, stb_o}, 32'd0);
        check("rst_adr", adr_o, 32'd0);
        check("rst_rsp", {29'd0, rsp_valid_o, rsp_status_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        #1 check("ready_before_edge", {31'd0, req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        check("ready_after_edge", {31'd0, req_ready_o}, 32'd1);
        chk_en = 1'b1;

        set_plan1(T_ACK, 1);
        do_txn(1'b1, 32'h0, 32'h0123_4567, 4'b1111);
        check("wr_status", {30'd0, last_st}, 32'd0);
        check("wr_bus_cycles", last_bus, 2);
        set_plan1(T_ACK, 0);
        do_txn(1'b0, 32'h0, 32'h0, 4'b1111);
        check("rd_back", last_dat, 32'h0123_4567);

        do_txn(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b1111);
        do_txn(1'b1, 32'h4, 32'h0000_AB00, 4'b0010);
        do_txn(1'b0, 32'h4, 32'h0, 4'b1111);
        check("byte_lane", last_dat, 32'hFFFF_ABFF);

        set_plan1(T_ERR, 0);
        do_txn(1'b0, 32'h4, 32'h0, 4'b1111);
        check("err_status", {30'd0, last_st}, 32'd1);
        check("err_dat", last_dat, 32'd0);
        check("err_bus_cycles", last_bus, 1);

        set_plan1(T_ACK, 0);
        do_txn(1'b1, 32'h8, 32'hDEAD_BEEF, 4'b1111);
        plan_n = 3;
        plan_t[0] = T_RTY; plan_w[0] = 0;
        plan_t[1] = T_RTY; plan_w[1] = 0;
        plan_t[2] = T_ACK; plan_w[2] = 0;
        do_txn(1'b0, 32'h8, 32'h0, 4'b1111);
        check("rty_ok_status", {30'd0, last_st}, 32'd0);
        check("rty_ok_dat", last_dat, 32'hDEAD_BEEF);
        check("rty_ok_issues", last_iss, 3);

        set_plan1(T_RTY, 0);
        do_txn(1'b0, 32'h8, 32'h0, 4'b1111);
        check("rty_exhaust_status", {30'd0, last_st}, 32'd2);
        check("rty_exhaust_issues", last_iss, 4);

        set_plan1(T_NONE, 0);
        do_txn(1'b0, 32'hC, 32'h0, 4'b1111);
        check("tmo_status", {30'd0, last_st}, 32'd3);
        check("tmo_bus_cycles", last_bus, 16);

        set_plan1(T_ACK, 15);
        do_txn(1'b0, 32'h0, 32'h0, 4'b1111);
        check("late_ack_status", {30'd0, last_st}, 32'd0);

        set_plan1(T_NONE, 0);
        start_req(1'b0, 32'h0, 32'h0, 4'b1111);
        repeat (3) @(posedge clk_i);
        #3;
        chk_en = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_cyc", {30'd0, cyc_o, stb_o}, 32'd0);
        check("rst_mid_adr", adr_o, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready_o}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk_en = 1'b1;
        check("no_rsp_in_reset", rsp_in_reset, 0);
        set_plan1(T_ACK, 2);
        do_txn(1'b0, 32'h0, 32'h0, 4'b1111);
        check("post_rst_read", last_dat, 32'h0123_4567);

        for (int n = 0; n < 300; n++) begin
            plan_n = $urandom_range(1, 5);
            for (int i = 0; i < plan_n; i++) begin
                r = $urandom_range(0, 9);
                plan_t[i] = (r < 5) ? T_ACK : (r == 5) ? T_ERR : (r < 9) ? T_RTY : T_NONE;
                plan_w[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            end
            do_txn(1'($urandom), {26'd0, 4'($urandom), 2'b00}, $urandom,
                   4'($urandom_range(1, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
